ospi_controller: RTL and testbench

Octal-SPI initiator (host-side master) that turns single-word host requests into OSPI bus transactions toward the team's OSPI flash model.
- Generates OSPI_CLK and chip select.
- Shifts out command, 24-bit address and write data eight bits per beat.
- Captures read data and returns it to the host on a one-cycle response strobe.
- Sits between the SoC register/bus side and the flash pins.

---
 rtl/ospi_controller_if.sv | 21 ++
 rtl/ospi_controller.sv | 267 ++++++++++++++++++++++++++
 tb/tb_ospi_controller.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ospi_controller_if.sv
// Host-side request/response bundle for the OSPI controller.
// The master modport belongs to the requester and the slave modport to the controller.
interface ospi_controller_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ospi_controller.sv
// Octal-SPI initiator: turns single-word host requests (read/write/erase)
// into OSPI bus transactions. It sends the opcode, a 24-bit address and
// write data one byte per beat, and gathers read data into a 32-bit response.
// Optional feature: define OSPI_CTRL_HOLD_EN to enable the hold_req/ospi_hold_n
// pause mechanism. Without it, hold_req is ignored and ospi_hold_n stays 1.
module ospi_controller #(
  parameter int         CLK_DIV     = 2,
  parameter int         DUMMY_BEATS = 4,
  parameter int         CS_HIGH_CYC = 3,
  parameter logic [7:0] OP_READ     = 8'h0B,
  parameter logic [7:0] OP_WRITE    = 8'h02,
  parameter logic [7:0] OP_ERASE    = 8'h20
) (
  input  logic                clk,
  input  logic                reset_n,
  ospi_controller_if.slave    host,
  input  logic                hold_req,
  output logic                ospi_clk,
  output logic                ospi_cs_n,
  output logic [7:0]          ospi_io_o,
  output logic                ospi_io_oe,
  input  logic [7:0]          ospi_io_i,
  output logic                ospi_hold_n
);

  localparam int DIV_W = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam int CS_W  = (CS_HIGH_CYC > 1) ? $clog2(CS_HIGH_CYC) : 1;

  localparam logic [DIV_W-1:0] HALF      = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BEAT_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [CS_W-1:0]  CS_LAST   = CS_W'(CS_HIGH_CYC - 1);
  localparam logic [3:0]       DUMMY_LAST = 4'(DUMMY_BEATS - 1);

  localparam logic [1:0] OPC_READ  = 2'd0;
  localparam logic [1:0] OPC_WRITE = 2'd1;
  localparam logic [1:0] OPC_ERASE = 2'd2;
  localparam logic [1:0] OPC_RSV   = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RSV,
    S_CS_SETUP,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_CS_HOLD
  } state_t;

  state_t           state;
  state_t           state_next;

  // Control counters: position inside a beat, beat index inside a phase,
  // and elapsed cycles of the chip-select high time.
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       beat_cnt;
  logic [CS_W-1:0]  cs_cnt;

  // Captured request and read shift register (datapath, not reset).
  logic [1:0]       op_q;
  logic [23:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rx_shift;
  logic [31:0]      rdata_q;

  logic             in_beat;
  logic             sck_low;
  logic             beat_end;
  logic             freeze;

  assign in_beat  = state inside {S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA};
  assign sck_low  = (div_cnt < HALF);
  assign beat_end = (div_cnt == BEAT_LAST);

`ifdef OSPI_CTRL_HOLD_EN
  logic hold_take;
  logic hold_active;

  // A pause is only honoured mid-transfer while SCK is low, so the clock
  // stays parked low and the IO lines keep their current values.
  assign hold_take = hold_req && in_beat && sck_low;
  assign freeze    = hold_take;

  // Registered copy of the pause drives the flash HOLD_N pin one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_active <= 1'b0;
    end else begin
      hold_active <= hold_take;
    end
  end

  assign ospi_hold_n = ~hold_active;
`else
  logic unused_hold_req;

  assign unused_hold_req = hold_req;
  assign freeze          = 1'b0;
  assign ospi_hold_n     = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: phases advance at the end of their last beat.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (host.cmd_valid) begin
          state_next = (host.cmd_op == OPC_RSV) ? S_RSV : S_CS_SETUP;
        end
      end
      S_RSV: begin
        state_next = S_IDLE;
      end
      S_CS_SETUP: begin
        if (div_cnt == HALF_LAST) begin
          state_next = S_CMD;
        end
      end
      S_CMD: begin
        if (beat_end) begin
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        if (beat_end && beat_cnt == 4'd2) begin
          if (op_q == OPC_READ) begin
            state_next = (DUMMY_BEATS == 0) ? S_RDATA : S_DUMMY;
          end else if (op_q == OPC_WRITE) begin
            state_next = S_WDATA;
          end else begin
            state_next = S_CS_HOLD;
          end
        end
      end
      S_DUMMY: begin
        if (beat_end && beat_cnt == DUMMY_LAST) begin
          state_next = S_RDATA;
        end
      end
      S_RDATA: begin
        if (beat_end && beat_cnt == 4'd3) begin
          state_next = S_CS_HOLD;
        end
      end
      S_WDATA: begin
        if (beat_end && beat_cnt == 4'd3) begin
          state_next = S_CS_HOLD;
        end
      end
      S_CS_HOLD: begin
        if (cs_cnt == CS_LAST) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Beat/phase counters; every phase starts from zero and a pause freezes them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      beat_cnt <= '0;
      cs_cnt   <= '0;
    end else if (!freeze) begin
      if (state_next != state) begin
        div_cnt  <= '0;
        beat_cnt <= '0;
        cs_cnt   <= '0;
      end else begin
        case (state)
          S_CS_SETUP: begin
            div_cnt <= div_cnt + 1'b1;
          end
          S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA: begin
            if (beat_end) begin
              div_cnt  <= '0;
              beat_cnt <= beat_cnt + 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          S_CS_HOLD: begin
            cs_cnt <= cs_cnt + 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Request capture on accept and read sampling on the clk edge where SCK rises.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && host.cmd_valid) begin
      op_q    <= host.cmd_op;
      addr_q  <= host.cmd_addr;
      wdata_q <= host.cmd_wdata;
    end
    if (state == S_RDATA && !freeze && div_cnt == HALF_LAST) begin
      rx_shift <= {rx_shift[23:0], ospi_io_i};
    end
  end

  // Response data only changes when a read completes, alongside rsp_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (state == S_RDATA && state_next == S_CS_HOLD) begin
      rdata_q <= rx_shift;
    end
  end

  assign host.rsp_rdata = rdata_q;

  // Output decode: pins are pure functions of state and counters.
  always_comb begin
    host.cmd_ready = (state == S_IDLE);
    host.rsp_valid = (state == S_RSV) || (state == S_CS_HOLD && cs_cnt == '0);
    ospi_cs_n      = !(in_beat || state == S_CS_SETUP);
    ospi_clk       = in_beat && !sck_low;
    ospi_io_oe     = state inside {S_CMD, S_ADDR, S_WDATA};
    ospi_io_o      = 8'h00;
    case (state)
      S_CMD: begin
        if (op_q == OPC_WRITE) begin
          ospi_io_o = OP_WRITE;
        end else if (op_q == OPC_ERASE) begin
          ospi_io_o = OP_ERASE;
        end else begin
          ospi_io_o = OP_READ;
        end
      end
      S_ADDR: begin
        case (beat_cnt)
          4'd0:    ospi_io_o = addr_q[23:16];
          4'd1:    ospi_io_o = addr_q[15:8];
          default: ospi_io_o = addr_q[7:0];
        endcase
      end
      S_WDATA: begin
        case (beat_cnt[1:0])
          2'd0:    ospi_io_o = wdata_q[31:24];
          2'd1:    ospi_io_o = wdata_q[23:16];
          2'd2:    ospi_io_o = wdata_q[15:8];
          default: ospi_io_o = wdata_q[7:0];
        endcase
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ospi_controller.sv
// Testbench for ospi_controller: directed host requests, a small flash
// responder, and a scoreboard that checks responses, latency and IO bytes.
module tb_ospi_controller;

  localparam int CS_HIGH   = 3;
  localparam int RD_FIRST  = 8;   // rising edge index of the first read byte (4 cmd/addr + 4 dummy)

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       hold_req = 1'b0;
  logic       ospi_clk;
  logic       ospi_cs_n;
  logic [7:0] ospi_io_o;
  logic       ospi_io_oe;
  logic [7:0] ospi_io_i = 8'h00;
  logic       ospi_hold_n;

  ospi_controller_if host_if ();

  ospi_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .host        (host_if),
    .hold_req    (hold_req),
    .ospi_clk    (ospi_clk),
    .ospi_cs_n   (ospi_cs_n),
    .ospi_io_o   (ospi_io_o),
    .ospi_io_oe  (ospi_io_oe),
    .ospi_io_i   (ospi_io_i),
    .ospi_hold_n (ospi_hold_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    int          due;
    int          beats;
    int          oe_beats;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  exp_io[$];
  logic [7:0]  rd_bytes[4];

  int   total = 0;
  int   bad = 0;
  int   rise_cnt = 0;
  int   oe_cnt = 0;
  int   cs_run = 0;
  logic prev_sck = 1'b0;
  logic prev_cs = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor and flash responder, all sampled on the falling clk edge.
  always @(negedge clk) begin
    if (host_if.rsp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid rdata=%h at cycle %0d, required none", host_if.rsp_rdata, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_rdata"}, host_if.rsp_rdata, e.rdata);
        chk({e.name, "_latency_cycle"}, cyc, e.due);
        chk({e.name, "_sck_rises"}, rise_cnt, e.beats);
        chk({e.name, "_oe_beats"}, oe_cnt, e.oe_beats);
      end
    end
    if (ospi_cs_n) begin
      cs_run++;
      rise_cnt = 0;
      oe_cnt = 0;
    end else begin
      if (prev_cs) begin
        total++;
        if (cs_run < CS_HIGH) begin
          bad++;
          $display("FAIL cs_gap: got %0d high cycles, required >= %0d", cs_run, CS_HIGH);
        end
        cs_run = 0;
      end
      if (ospi_clk && !prev_sck) begin
        rise_cnt++;
        if (ospi_io_oe) begin
          oe_cnt++;
          if (exp_io.size() == 0) begin
            total++;
            bad++;
            $display("FAIL io_extra_beat: got byte %h with oe=1, required no driven beat", ospi_io_o);
          end else begin
            chk("io_byte", {24'h0, ospi_io_o}, {24'h0, exp_io.pop_front()});
          end
        end
      end
    end
    prev_sck = ospi_clk;
    prev_cs  = ospi_cs_n;
    ospi_io_i = (rise_cnt >= RD_FIRST && rise_cnt < RD_FIRST + 4) ? rd_bytes[rise_cnt - RD_FIRST] : 8'h00;
  end

  task automatic push_hdr(input logic [7:0] opc, input logic [23:0] addr);
    exp_io.push_back(opc);
    exp_io.push_back(addr[23:16]);
    exp_io.push_back(addr[15:8]);
    exp_io.push_back(addr[7:0]);
  endtask

  // Called on a falling edge; returns the cycle in which the request was accepted.
  task automatic issue(input string name, input logic [1:0] op, input logic [23:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int lat,
                       input int beats, input int oe_beats, input bit keep, output int acc);
    exp_t e;
    host_if.cmd_op    = op;
    host_if.cmd_addr  = addr;
    host_if.cmd_wdata = wd;
    host_if.cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      if (host_if.cmd_ready) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc < 0) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout: got cmd_ready=0 for 200 cycles, required 1", name);
      host_if.cmd_valid = 1'b0;
    end else begin
      e.name = name;
      e.rdata = exp_rd;
      e.due = acc + lat;
      e.beats = beats;
      e.oe_beats = oe_beats;
      exp_q.push_back(e);
      @(negedge clk);
      if (!keep) host_if.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_rsp_timeout: got %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish after 20000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    int a2;
    int hold_lat;
    host_if.cmd_valid = 1'b0;
    host_if.cmd_op    = 2'd0;
    host_if.cmd_addr  = 24'h0;
    host_if.cmd_wdata = 32'h0;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready", host_if.cmd_ready, 1);
    chk("rst_rsp_valid", host_if.rsp_valid, 0);
    chk("rst_rsp_rdata", host_if.rsp_rdata, 0);
    chk("rst_ospi_clk", ospi_clk, 0);
    chk("rst_cs_n", ospi_cs_n, 1);
    chk("rst_io_o", ospi_io_o, 0);
    chk("rst_io_oe", ospi_io_oe, 0);
    chk("rst_hold_n", ospi_hold_n, 1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read with default timing.
    rd_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    push_hdr(8'h0B, 24'h000010);
    issue("read", 2'd0, 24'h000010, 32'h0, 32'hDEADBEEF, 51, 12, 4, 1'b0, a);
    wait_done("read");

    // Write: 8 driven beats, response data unchanged.
    push_hdr(8'h02, 24'h0000FF);
    exp_io.push_back(8'h12);
    exp_io.push_back(8'h34);
    exp_io.push_back(8'h56);
    exp_io.push_back(8'h78);
    issue("write", 2'd1, 24'h0000FF, 32'h12345678, 32'hDEADBEEF, 35, 8, 8, 1'b0, a);
    wait_done("write");

    // Erase: command and address only.
    push_hdr(8'h20, 24'h000020);
    issue("erase", 2'd2, 24'h000020, 32'hFFFFFFFF, 32'hDEADBEEF, 19, 4, 4, 1'b0, a);
    wait_done("erase");

    // Reserved op: immediate response, no bus activity.
    issue("rsv", 2'd3, 24'hABCDEF, 32'h0, 32'hDEADBEEF, 1, 0, 0, 1'b0, a);
    wait_done("rsv");

    // Back-to-back reads with cmd_valid held high.
    rd_bytes = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
    push_hdr(8'h0B, 24'h123456);
    push_hdr(8'h0B, 24'h123456);
    issue("b2b_first", 2'd0, 24'h123456, 32'h0, 32'hCAFEBABE, 51, 12, 4, 1'b1, a);
    issue("b2b_second", 2'd0, 24'h123456, 32'h0, 32'hCAFEBABE, 51, 12, 4, 1'b0, a2);
    chk("b2b_accept_spacing", a2 - a, 51 + CS_HIGH);
    wait_done("b2b");

    // Reset asserted during the second address beat.
    push_hdr(8'h0B, 24'h000300);
    issue("aborted", 2'd0, 24'h000300, 32'h0, 32'h0, 51, 12, 4, 1'b0, a);
    while (cyc < a + 12) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_cmd_ready", host_if.cmd_ready, 1);
    chk("abort_rsp_valid", host_if.rsp_valid, 0);
    chk("abort_rsp_rdata", host_if.rsp_rdata, 0);
    chk("abort_ospi_clk", ospi_clk, 0);
    chk("abort_cs_n", ospi_cs_n, 1);
    chk("abort_io_o", ospi_io_o, 0);
    chk("abort_io_oe", ospi_io_oe, 0);
    exp_q.delete();
    exp_io.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    rd_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    push_hdr(8'h0B, 24'h000ABC);
    issue("after_reset", 2'd0, 24'h000ABC, 32'h0, 32'h01020304, 51, 12, 4, 1'b0, a);
    wait_done("after_reset");

    // Pause for 10 cycles during the read data phase.
`ifdef OSPI_CTRL_HOLD_EN
    hold_lat = 61;
`else
    hold_lat = 51;
`endif
    rd_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_hdr(8'h0B, 24'h000004);
    issue("hold_read", 2'd0, 24'h000004, 32'h0, 32'h11223344, hold_lat, 12, 4, 1'b0, a);
    while (cyc < a + 39) @(negedge clk);
    hold_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
`ifdef OSPI_CTRL_HOLD_EN
      if (cyc == a + 40) chk("hold_n_active", ospi_hold_n, 0);
      if (cyc == a + 48) chk("hold_n_still_active", ospi_hold_n, 0);
`else
      if (cyc == a + 40) chk("hold_n_tied", ospi_hold_n, 1);
`endif
      if (cyc == a + 44) chk("hold_sck_low", ospi_clk, 0);
    end
    hold_req = 1'b0;
    @(negedge clk);
    chk("hold_n_released", ospi_hold_n, 1);
    wait_done("hold_read");

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
